// File: rtl/sv32_pkg.sv
// Shared Sv32 page-table-walk types: PTE layout, TLB update word packing and walker states.
package sv32_pkg;

  localparam int PTE_SIZE   = 4;
  localparam int PTE_SHIFT  = 2;
  localparam int PAGE_SHIFT = 12;
  localparam int UPD_ASID_W = 9;

  typedef struct packed {
    logic [11:0] ppn1;
    logic [9:0]  ppn0;
    logic [1:0]  rsw;
    logic        d;
    logic        a;
    logic        g;
    logic        u;
    logic        x;
    logic        w;
    logic        r;
    logic        v;
  } pte_t;

  // Field order matches the 63-bit word consumed by the TLB update port
  typedef struct packed {
    logic                  valid;
    logic                  is4M;
    logic [19:0]           vpn;
    logic [UPD_ASID_W-1:0] asid;
    pte_t                  pte;
  } tlb_update_t;

  typedef enum logic [2:0] {
    IDLE,
    L1_REQ,
    L1_WAIT,
    L0_REQ,
    L0_WAIT,
    UPDATE,
    FAULT
  } ptw_state_e;

endpackage

// File: rtl/sv32_pte_decode.sv
// Combinational Sv32 PTE classification shared by both walk levels.
module sv32_pte_decode
  import sv32_pkg::*;
(
  input  logic       i_v,
  input  logic       i_r,
  input  logic       i_w,
  input  logic       i_x,
  input  logic [9:0] i_ppn0,
  output logic       o_valid,
  output logic       o_leaf,
  output logic       o_misaligned
);

  // Write-without-read is a reserved encoding and is treated like an invalid entry
  assign o_valid      = i_v && !(i_w && !i_r);
  assign o_leaf       = i_r || i_x;
  assign o_misaligned = (i_ppn0 != 10'd0);

endmodule

// File: rtl/sv32_ptw_walker.sv
// Sv32 two-level page-table walker: one miss at a time, emits a TLB update word or a fault pulse.
module sv32_ptw_walker
  import sv32_pkg::*;
#(
  parameter int ASID_WIDTH = 9,
  parameter int PA_WIDTH   = 34
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic [21:0]           satp_ppn_i,
  input  logic                  miss_valid_i,
  output logic                  miss_ready_o,
  input  logic [31:0]           miss_vaddr_i,
  input  logic [ASID_WIDTH-1:0] miss_asid_i,
  output logic                  mem_req_o,
  input  logic                  mem_gnt_i,
  output logic [PA_WIDTH-1:0]   mem_addr_o,
  input  logic                  mem_rvalid_i,
  input  logic [31:0]           mem_rdata_i,
  output logic [62:0]           update_o,
  output logic                  fault_o,
  output logic                  busy_o
);

  ptw_state_e            r_state;
  ptw_state_e            w_nextState;
  logic [19:0]           r_vpn;
  logic [ASID_WIDTH-1:0] r_asid;
  logic [21:0]           r_satp;
  logic [21:0]           r_ppn;
  logic                  r_abort;
  logic                  w_abortNext;
  tlb_update_t           r_update;

  pte_t                  w_pte;
  logic                  w_pteValid;
  logic                  w_pteLeaf;
  logic                  w_pteMisaligned;
  logic                  w_accept;
  logic                  w_inWait;
  logic [PA_WIDTH-1:0]   w_l1Addr;
  logic [PA_WIDTH-1:0]   w_l0Addr;

  assign w_pte = pte_t'(mem_rdata_i);

  sv32_pte_decode u_decode (
    .i_v          (w_pte.v),
    .i_r          (w_pte.r),
    .i_w          (w_pte.w),
    .i_x          (w_pte.x),
    .i_ppn0       (w_pte.ppn0),
    .o_valid      (w_pteValid),
    .o_leaf       (w_pteLeaf),
    .o_misaligned (w_pteMisaligned)
  );

  assign w_accept = (r_state == IDLE) && miss_valid_i && !flush_i;
  assign w_inWait = (r_state == L1_WAIT) || (r_state == L0_WAIT);

  // Root and PPN are held in registers so the address stays stable while gnt is low
  assign w_l1Addr = (PA_WIDTH'(r_satp) << PAGE_SHIFT) + (PA_WIDTH'(r_vpn[19:10]) << PTE_SHIFT);
  assign w_l0Addr = (PA_WIDTH'(r_ppn)  << PAGE_SHIFT) + (PA_WIDTH'(r_vpn[9:0])   << PTE_SHIFT);

  always_comb begin
    w_nextState = r_state;
    w_abortNext = r_abort;
    case (r_state)
      IDLE: begin
        w_abortNext = 1'b0;
        if (w_accept) w_nextState = L1_REQ;
      end
      L1_REQ, L0_REQ: begin
        // A flush that coincides with gnt still has a read in flight, so it becomes an abort
        if (mem_gnt_i) begin
          w_abortNext = flush_i;
          if (r_state == L1_REQ) w_nextState = L1_WAIT;
          else                   w_nextState = L0_WAIT;
        end else if (flush_i) begin
          w_nextState = IDLE;
        end
      end
      L1_WAIT, L0_WAIT: begin
        if (flush_i) w_abortNext = 1'b1;
        if (mem_rvalid_i) begin
          if (r_abort || flush_i)                           w_nextState = IDLE;
          else if (!w_pteValid)                             w_nextState = FAULT;
          else if (w_pteLeaf && r_state == L1_WAIT)         w_nextState = w_pteMisaligned ? FAULT : UPDATE;
          else if (w_pteLeaf)                               w_nextState = UPDATE;
          else if (r_state == L1_WAIT)                      w_nextState = L0_REQ;
          else                                              w_nextState = FAULT;
        end
      end
      UPDATE:  w_nextState = IDLE;
      FAULT:   w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_abort  <= 1'b0;
      r_vpn    <= '0;
      r_asid   <= '0;
      r_satp   <= '0;
      r_ppn    <= '0;
      r_update <= '0;
    end else begin
      r_state <= w_nextState;
      r_abort <= w_abortNext;
      if (w_accept) begin
        r_vpn  <= miss_vaddr_i[31:12];
        r_asid <= miss_asid_i;
        r_satp <= satp_ppn_i;
      end
      if (r_state == L1_WAIT && mem_rvalid_i) begin
        r_ppn <= {w_pte.ppn1, w_pte.ppn0};
      end
      if (w_inWait && mem_rvalid_i) begin
        r_update <= '{valid: 1'b1,
                      is4M:  (r_state == L1_WAIT),
                      vpn:   r_vpn,
                      asid:  UPD_ASID_W'(r_asid),
                      pte:   w_pte};
      end
    end
  end

  assign miss_ready_o = (r_state == IDLE);
  assign mem_req_o    = (r_state == L1_REQ) || (r_state == L0_REQ);
  assign mem_addr_o   = (r_state == L1_REQ) ? w_l1Addr :
                        (r_state == L0_REQ) ? w_l0Addr : '0;
  assign update_o     = (r_state == UPDATE && !flush_i) ? r_update : '0;
  assign fault_o      = (r_state == FAULT);
  assign busy_o       = (r_state != IDLE);

endmodule

// File: tb/tb_sv32_ptw_walker.sv
// Directed bench for sv32_ptw_walker: a vector table of complete walks plus hand-written flush/reset sequences.
module tb_sv32_ptw_walker;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic [21:0] satp_ppn_i;
  logic        miss_valid_i;
  logic        miss_ready_o;
  logic [31:0] miss_vaddr_i;
  logic [8:0]  miss_asid_i;
  logic        mem_req_o;
  logic        mem_gnt_i;
  logic [33:0] mem_addr_o;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic [62:0] update_o;
  logic        fault_o;
  logic        busy_o;

  always #5 clk_i = ~clk_i;

  sv32_ptw_walker #(.ASID_WIDTH(9), .PA_WIDTH(34)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .flush_i      (flush_i),
    .satp_ppn_i   (satp_ppn_i),
    .miss_valid_i (miss_valid_i),
    .miss_ready_o (miss_ready_o),
    .miss_vaddr_i (miss_vaddr_i),
    .miss_asid_i  (miss_asid_i),
    .mem_req_o    (mem_req_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_addr_o   (mem_addr_o),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .update_o     (update_o),
    .fault_o      (fault_o),
    .busy_o       (busy_o)
  );

  typedef struct {
    logic [21:0] satp;
    logic [31:0] vaddr;
    logic [8:0]  asid;
    logic [31:0] l1Pte;
    logic [31:0] l0Pte;
    int          gntDelay;
    logic [62:0] expUpd;
    int          expFaults;
    int          expReads;
    logic [33:0] expAddr0;
    logic [33:0] expAddr1;
    int          expLat;
  } vec_t;

  typedef struct {
    logic [62:0] upd;
    int          updCount;
    int          faults;
    int          reads;
    logic [33:0] addr0;
    logic [33:0] addr1;
    int          addrChanges;
    int          updCycle;
  } res_t;

  int   checkCount = 0;
  int   passCount  = 0;
  vec_t vecs[8];
  res_t res;
  logic sawUpd;
  logic sawFault;

  function automatic logic [62:0] mkUpd(input logic is4M, input logic [19:0] vpn,
                                        input logic [8:0] asid, input logic [31:0] pte);
    return {1'b1, is4M, vpn, asid, pte};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic nextCycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic startMiss(input logic [21:0] satp, input logic [31:0] vaddr, input logic [8:0] asid);
    satp_ppn_i   = satp;
    miss_vaddr_i = vaddr;
    miss_asid_i  = asid;
    miss_valid_i = 1'b1;
    nextCycle();
    miss_valid_i = 1'b0;
  endtask

  task automatic observe();
    if (update_o != '0) sawUpd = 1'b1;
    if (fault_o) sawFault = 1'b1;
  endtask

  // Memory responder: gnt after gntDelay cycles of req, rvalid the cycle after gnt
  task automatic applyStimulus(input vec_t v, output res_t r);
    int          reqAge;
    logic        pendingRvalid;
    logic [33:0] reqAddr;
    r.upd = '0; r.updCount = 0; r.faults = 0; r.reads = 0;
    r.addr0 = '0; r.addr1 = '0; r.addrChanges = 0; r.updCycle = -1;
    reqAge = 0; pendingRvalid = 1'b0; reqAddr = '0;
    startMiss(v.satp, v.vaddr, v.asid);
    for (int cyc = 1; cyc <= 20; cyc++) begin
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
      if (pendingRvalid) begin
        mem_rvalid_i  = 1'b1;
        mem_rdata_i   = (r.reads == 1) ? v.l1Pte : v.l0Pte;
        pendingRvalid = 1'b0;
      end else if (mem_req_o) begin
        if (reqAge == 0) reqAddr = mem_addr_o;
        else if (mem_addr_o !== reqAddr) r.addrChanges++;
        if (reqAge >= v.gntDelay) begin
          mem_gnt_i = 1'b1;
          if (r.reads == 0) r.addr0 = mem_addr_o;
          else              r.addr1 = mem_addr_o;
          r.reads++;
          pendingRvalid = 1'b1;
          reqAge = 0;
        end else begin
          reqAge++;
        end
      end
      if (update_o[62]) begin
        r.upd = update_o;
        r.updCount++;
        r.updCycle = cyc;
      end
      if (fault_o) r.faults++;
      nextCycle();
    end
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs[0] = '{22'h100, 32'h00403000, 9'h05A, 32'h00080001, 32'h1234500F, 1,
                mkUpd(1'b0, 20'h00403, 9'h05A, 32'h1234500F), 0, 2, 34'h100004, 34'h20000C, 7};
    vecs[1] = '{22'h100, 32'h00403000, 9'h033, 32'h2000000F, 32'h00000000, 1,
                mkUpd(1'b1, 20'h00403, 9'h033, 32'h2000000F), 0, 1, 34'h100004, 34'h0, 0};
    vecs[2] = '{22'h100, 32'h00403000, 9'h011, 32'h2000040F, 32'h00000000, 1,
                63'h0, 1, 1, 34'h100004, 34'h0, 0};
    vecs[3] = '{22'h100, 32'h00403000, 9'h011, 32'h00000000, 32'h00000000, 1,
                63'h0, 1, 1, 34'h100004, 34'h0, 0};
    vecs[4] = '{22'h100, 32'h00403000, 9'h011, 32'h00080001, 32'h00000001, 1,
                63'h0, 1, 2, 34'h100004, 34'h20000C, 0};
    vecs[5] = '{22'h3FFFFF, 32'h80C05123, 9'h1FF, 32'hFFFFFC01, 32'h000000CB, 4,
                mkUpd(1'b0, 20'h80C05, 9'h1FF, 32'h000000CB), 0, 2, 34'h3FFFFF80C, 34'h3FFFFF014, 0};
    vecs[6] = '{22'h100, 32'h00403000, 9'h011, 32'h00080001, 32'h00000005, 1,
                63'h0, 1, 2, 34'h100004, 34'h20000C, 0};
    vecs[7] = '{22'h000, 32'h00000FFF, 9'h000, 32'h00000009, 32'h00000000, 1,
                mkUpd(1'b1, 20'h00000, 9'h000, 32'h00000009), 0, 1, 34'h0, 34'h0, 0};

    rst_i = 1'b1; flush_i = 1'b0; satp_ppn_i = '0; miss_valid_i = 1'b0;
    miss_vaddr_i = '0; miss_asid_i = '0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_i = 1'b0;
    #1;

    checkOutput("reset miss_ready", 64'(miss_ready_o), 64'd1);
    checkOutput("reset mem_req",    64'(mem_req_o),    64'd0);
    checkOutput("reset mem_addr",   64'(mem_addr_o),   64'd0);
    checkOutput("reset update",     64'(update_o),     64'd0);
    checkOutput("reset fault",      64'(fault_o),      64'd0);
    checkOutput("reset busy",       64'(busy_o),       64'd0);
    nextCycle();

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i], res);
      checkOutput($sformatf("v%0d update", i),      64'(res.upd),         64'(vecs[i].expUpd));
      checkOutput($sformatf("v%0d updCount", i),    64'(res.updCount),    vecs[i].expUpd[62] ? 64'd1 : 64'd0);
      checkOutput($sformatf("v%0d faults", i),      64'(res.faults),      64'(vecs[i].expFaults));
      checkOutput($sformatf("v%0d reads", i),       64'(res.reads),       64'(vecs[i].expReads));
      checkOutput($sformatf("v%0d l1 addr", i),     64'(res.addr0),       64'(vecs[i].expAddr0));
      if (vecs[i].expReads == 2)
        checkOutput($sformatf("v%0d l0 addr", i),   64'(res.addr1),       64'(vecs[i].expAddr1));
      checkOutput($sformatf("v%0d addr stable", i), 64'(res.addrChanges), 64'd0);
      if (vecs[i].expLat != 0)
        checkOutput($sformatf("v%0d latency", i),   64'(res.updCycle),    64'(vecs[i].expLat));
      checkOutput($sformatf("v%0d idle after", i),  64'(miss_ready_o),    64'd1);
    end

    // Flush during L1_WAIT, data arrives three cycles later and must be dropped
    sawUpd = 1'b0; sawFault = 1'b0;
    startMiss(22'h100, 32'h00403000, 9'h001);
    mem_gnt_i = 1'b1;
    nextCycle();
    mem_gnt_i = 1'b0;
    miss_valid_i = 1'b1;
    checkOutput("wait miss_ready", 64'(miss_ready_o), 64'd0);
    flush_i = 1'b1;
    nextCycle();
    flush_i = 1'b0; miss_valid_i = 1'b0;
    observe();
    nextCycle();
    observe();
    checkOutput("abort still busy", 64'(busy_o), 64'd1);
    nextCycle();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h2000000F;
    observe();
    nextCycle();
    mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    checkOutput("abort ready next", 64'(miss_ready_o), 64'd1);
    observe();
    nextCycle();
    observe();
    checkOutput("abort no update", 64'(sawUpd), 64'd0);
    checkOutput("abort no fault", 64'(sawFault), 64'd0);

    // Flush in L1_REQ before gnt drops straight back to idle
    startMiss(22'h100, 32'h00403000, 9'h002);
    checkOutput("req flush mem_req", 64'(mem_req_o), 64'd1);
    flush_i = 1'b1;
    nextCycle();
    flush_i = 1'b0;
    checkOutput("req flush idle", 64'(miss_ready_o), 64'd1);
    checkOutput("req flush no req", 64'(mem_req_o), 64'd0);

    // Flush coinciding with the UPDATE cycle suppresses the update
    startMiss(22'h100, 32'h00403000, 9'h003);
    mem_gnt_i = 1'b1;
    nextCycle();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h2000000F;
    nextCycle();
    mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    flush_i = 1'b1;
    #1;
    checkOutput("update flush suppressed", 64'(update_o), 64'd0);
    checkOutput("update flush no fault", 64'(fault_o), 64'd0);
    nextCycle();
    flush_i = 1'b0;
    checkOutput("update flush idle", 64'(miss_ready_o), 64'd1);

    // Miss together with flush in IDLE is not accepted
    miss_valid_i = 1'b1; flush_i = 1'b1;
    satp_ppn_i = 22'h100; miss_vaddr_i = 32'h00403000;
    nextCycle();
    miss_valid_i = 1'b0; flush_i = 1'b0;
    checkOutput("idle flush blocks busy", 64'(busy_o), 64'd0);
    checkOutput("idle flush blocks req", 64'(mem_req_o), 64'd0);

    // Asynchronous reset in L0_WAIT, then a stray rvalid in IDLE
    sawUpd = 1'b0; sawFault = 1'b0;
    startMiss(22'h100, 32'h00403000, 9'h004);
    mem_gnt_i = 1'b1;
    nextCycle();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h00080001;
    nextCycle();
    mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    checkOutput("rst seq l0 addr", 64'(mem_addr_o), 64'h20000C);
    mem_gnt_i = 1'b1;
    nextCycle();
    mem_gnt_i = 1'b0;
    checkOutput("rst seq in l0 wait", 64'(busy_o), 64'd1);
    #2 rst_i = 1'b1;
    #1;
    checkOutput("async rst busy", 64'(busy_o), 64'd0);
    checkOutput("async rst ready", 64'(miss_ready_o), 64'd1);
    #1 rst_i = 1'b0;
    nextCycle();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1234500F;
    observe();
    nextCycle();
    mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    observe();
    nextCycle();
    observe();
    checkOutput("stray rvalid no update", 64'(sawUpd), 64'd0);
    checkOutput("stray rvalid no fault", 64'(sawFault), 64'd0);
    checkOutput("stray rvalid idle", 64'(busy_o), 64'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
